// File: rtl/au_updown_counter.sv
// Loadable, cascadable up/down counter wrapped around a single incrementer/decrementer.
// Also holds AU_incdec_c, the combinational +/-ci stage that the counter feeds back through.

module AU_incdec_c #(
  parameter int WIDTH = 8,
  parameter int ARCH  = 0
) (
  input  logic [WIDTH-1:0] a,
  input  logic             ci,
  input  logic             inc_dec,
  output logic [WIDTH-1:0] z,
  output logic             co
);

  // co is the carry out on increment and the borrow out on decrement.
  generate
    if (ARCH == 0) begin : g_behav
      logic [WIDTH:0] sum;

      always_comb begin
        sum = '0;
        if (inc_dec)
          sum = {1'b0, a} - {{WIDTH{1'b0}}, ci};
        else
          sum = {1'b0, a} + {{WIDTH{1'b0}}, ci};
      end

      assign z  = sum[WIDTH-1:0];
      assign co = sum[WIDTH];
    end else begin : g_ripple
      // Borrow propagates through zeros, carry through ones, hence the XOR with direction.
      logic [WIDTH:0] chain;

      assign chain[0] = ci;
      for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign z[i]         = a[i] ^ chain[i];
        assign chain[i + 1] = (a[i] ^ inc_dec) & chain[i];
      end
      assign co = chain[WIDTH];
    end
  endgenerate

endmodule

module au_updown_counter #(
  parameter int WIDTH    = 8,
  parameter int ARCH     = 0,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             inc_dec,
  output logic [WIDTH-1:0] cnt,
  output logic             wrap,
  output logic             casc_co,
  output logic             at_bnd
);

  logic [WIDTH-1:0] z;
  logic             co;

  AU_incdec_c #(
    .WIDTH (WIDTH),
    .ARCH  (ARCH)
  ) u_incdec (
    .a       (cnt),
    .ci      (en),
    .inc_dec (inc_dec),
    .z       (z),
    .co      (co)
  );

  // In saturate mode a step that would carry/borrow is blocked, but still flagged.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt  <= '0;
      wrap <= 1'b0;
    end else if (clr) begin
      cnt  <= '0;
      wrap <= 1'b0;
    end else if (load) begin
      cnt  <= load_val;
      wrap <= 1'b0;
    end else if (en) begin
      if ((SATURATE == 0) || !co)
        cnt <= z;
      wrap <= co;
    end else begin
      wrap <= 1'b0;
    end
  end

  assign casc_co = en & co & ~clr & ~load & rst_n;
  assign at_bnd  = inc_dec ? (cnt == '0) : (cnt == '1);

endmodule

// File: tb/tb_au_updown_counter.sv
// Directed self-checking bench for au_updown_counter: wrap, saturate, cascade and a 4-bit sweep.

module tb_au_updown_counter;

  logic clk;
  logic rst_n;

  // Group A: 8-bit wrap and saturate instances sharing inputs
  logic       a_clr, a_load, a_en, a_dir;
  logic [7:0] a_val;
  logic [7:0] w_cnt, s_cnt;
  logic       w_wrap, w_casc, w_bnd, s_wrap, s_casc, s_bnd;

  // Group C: two 8-bit slices chained into a 16-bit counter
  logic       c_clr, c_load, c_en, c_dir;
  logic [7:0] c_lo_val, c_hi_val;
  logic [7:0] lo_cnt, hi_cnt;
  logic       lo_wrap, lo_casc, lo_bnd, hi_wrap, hi_casc, hi_bnd;

  // Group E: 4-bit wrap and saturate instances for the sweep
  logic       e_clr, e_load, e_en, e_dir;
  logic [3:0] e_val;
  logic [3:0] ew_cnt, es_cnt;
  logic       ew_wrap, ew_casc, ew_bnd, es_wrap, es_casc, es_bnd;

  int tests_run;
  int tests_failed;

  au_updown_counter #(.WIDTH(8), .ARCH(0), .SATURATE(0)) u_wrap (
    .clk(clk), .rst_n(rst_n), .clr(a_clr), .load(a_load), .load_val(a_val),
    .en(a_en), .inc_dec(a_dir), .cnt(w_cnt), .wrap(w_wrap), .casc_co(w_casc), .at_bnd(w_bnd));

  au_updown_counter #(.WIDTH(8), .ARCH(1), .SATURATE(1)) u_sat (
    .clk(clk), .rst_n(rst_n), .clr(a_clr), .load(a_load), .load_val(a_val),
    .en(a_en), .inc_dec(a_dir), .cnt(s_cnt), .wrap(s_wrap), .casc_co(s_casc), .at_bnd(s_bnd));

  au_updown_counter #(.WIDTH(8), .ARCH(0), .SATURATE(0)) u_lo (
    .clk(clk), .rst_n(rst_n), .clr(c_clr), .load(c_load), .load_val(c_lo_val),
    .en(c_en), .inc_dec(c_dir), .cnt(lo_cnt), .wrap(lo_wrap), .casc_co(lo_casc), .at_bnd(lo_bnd));

  au_updown_counter #(.WIDTH(8), .ARCH(1), .SATURATE(0)) u_hi (
    .clk(clk), .rst_n(rst_n), .clr(c_clr), .load(c_load), .load_val(c_hi_val),
    .en(lo_casc), .inc_dec(c_dir), .cnt(hi_cnt), .wrap(hi_wrap), .casc_co(hi_casc), .at_bnd(hi_bnd));

  au_updown_counter #(.WIDTH(4), .ARCH(1), .SATURATE(0)) u_e_wrap (
    .clk(clk), .rst_n(rst_n), .clr(e_clr), .load(e_load), .load_val(e_val),
    .en(e_en), .inc_dec(e_dir), .cnt(ew_cnt), .wrap(ew_wrap), .casc_co(ew_casc), .at_bnd(ew_bnd));

  au_updown_counter #(.WIDTH(4), .ARCH(0), .SATURATE(1)) u_e_sat (
    .clk(clk), .rst_n(rst_n), .clr(e_clr), .load(e_load), .load_val(e_val),
    .en(e_en), .inc_dec(e_dir), .cnt(es_cnt), .wrap(es_wrap), .casc_co(es_casc), .at_bnd(es_bnd));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests_run++;
    assert (obs === exp)
    else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic clr_i, input logic load_i, input logic [7:0] val_i,
                               input logic en_i, input logic dir_i);
    a_clr  = clr_i;
    a_load = load_i;
    a_val  = val_i;
    a_en   = en_i;
    a_dir  = dir_i;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin : main
    logic [7:0] exp_up [3];
    logic       exp_upw [3];
    logic [7:0] exp_sat [5];
    logic       exp_satw [5];
    int         z, co, bnd;

    tests_run    = 0;
    tests_failed = 0;
    exp_up   = '{8'hFF, 8'h00, 8'h01};
    exp_upw  = '{1'b0, 1'b1, 1'b0};
    exp_sat  = '{8'hFE, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    exp_satw = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

    rst_n = 1'b0;
    c_clr = 0; c_load = 0; c_en = 0; c_dir = 0; c_lo_val = 0; c_hi_val = 0;
    e_clr = 0; e_load = 0; e_en = 0; e_dir = 0; e_val = 0;
    applyStimulus(0, 0, 8'h00, 1, 1);
    tick();

    // Reset state; count-down from zero would borrow, but reset must mask casc_co
    checkOutput("rst_cnt", {8'h0, w_cnt}, 16'h0000);
    checkOutput("rst_wrap", {15'h0, w_wrap}, 16'h0000);
    checkOutput("rst_casc", {15'h0, w_casc}, 16'h0000);
    checkOutput("rst_bnd_down", {15'h0, w_bnd}, 16'h0001);
    applyStimulus(0, 0, 8'h00, 1, 0);
    checkOutput("rst_bnd_up", {15'h0, w_bnd}, 16'h0000);

    // Five up steps, then a one-edge reset
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    checkOutput("up5_cnt", {8'h0, w_cnt}, 16'h0005);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checkOutput("midrst_cnt", {8'h0, w_cnt}, 16'h0000);
    checkOutput("midrst_wrap", {15'h0, w_wrap}, 16'h0000);

    // Count to 0x10, then clr beats load
    for (int i = 0; i < 16; i++) tick();
    checkOutput("up16_cnt", {8'h0, w_cnt}, 16'h0010);
    applyStimulus(1, 1, 8'h55, 1, 0);
    tick();
    checkOutput("clr_vs_load", {8'h0, w_cnt}, 16'h0000);

    // Wrap mode across 0xFF going up
    applyStimulus(0, 1, 8'hFE, 0, 0);
    tick();
    applyStimulus(0, 0, 8'h00, 1, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput($sformatf("wrap_up_cnt%0d", i), {8'h0, w_cnt}, {8'h0, exp_up[i]});
      checkOutput($sformatf("wrap_up_flag%0d", i), {15'h0, w_wrap}, {15'h0, exp_upw[i]});
    end

    // Down from 0x01 through zero
    applyStimulus(0, 0, 8'h00, 1, 1);
    tick();
    checkOutput("wrap_dn_cnt0", {8'h0, w_cnt}, 16'h0000);
    checkOutput("wrap_dn_flag0", {15'h0, w_wrap}, 16'h0000);
    checkOutput("wrap_dn_casc", {15'h0, w_casc}, 16'h0001);
    tick();
    checkOutput("wrap_dn_cnt1", {8'h0, w_cnt}, 16'h00FF);
    checkOutput("wrap_dn_flag1", {15'h0, w_wrap}, 16'h0001);

    // Saturate mode pinned at all-ones
    applyStimulus(0, 1, 8'hFD, 0, 0);
    tick();
    applyStimulus(0, 0, 8'h00, 1, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput($sformatf("sat_up_cnt%0d", i), {8'h0, s_cnt}, {8'h0, exp_sat[i]});
      checkOutput($sformatf("sat_up_flag%0d", i), {15'h0, s_wrap}, {15'h0, exp_satw[i]});
    end
    checkOutput("sat_bnd_up", {15'h0, s_bnd}, 16'h0001);
    applyStimulus(0, 0, 8'h00, 1, 1);
    tick();
    checkOutput("sat_dn_cnt", {8'h0, s_cnt}, 16'h00FE);
    checkOutput("sat_dn_flag", {15'h0, s_wrap}, 16'h0000);

    // Saturate at zero going down; wrap instance wraps on the same step
    applyStimulus(1, 0, 8'h00, 0, 1);
    tick();
    applyStimulus(0, 0, 8'h00, 1, 1);
    tick();
    checkOutput("sat_zero_cnt", {8'h0, s_cnt}, 16'h0000);
    checkOutput("sat_zero_flag", {15'h0, s_wrap}, 16'h0001);
    checkOutput("wrap_zero_cnt", {8'h0, w_cnt}, 16'h00FF);

    // load beats en; casc_co masked by load
    applyStimulus(0, 1, 8'h80, 1, 0);
    checkOutput("load_casc_mask", {15'h0, w_casc}, 16'h0000);
    tick();
    checkOutput("load_en_cnt", {8'h0, w_cnt}, 16'h0080);
    checkOutput("load_en_wrap", {15'h0, w_wrap}, 16'h0000);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, 8'h00, 0, logic'(i[0]));
      tick();
      checkOutput($sformatf("hold_cnt%0d", i), {8'h0, w_cnt}, 16'h0080);
      checkOutput($sformatf("hold_wrap%0d", i), {15'h0, w_wrap}, 16'h0000);
    end

    // Cascade: 0x00FF + 1 and back
    c_hi_val = 8'h00; c_lo_val = 8'hFF; c_load = 1; c_en = 0; c_dir = 0;
    tick();
    c_load = 0; c_en = 1;
    #1;
    checkOutput("casc_up_co", {15'h0, lo_casc}, 16'h0001);
    tick();
    c_en = 0;
    checkOutput("casc_up_cnt", {hi_cnt, lo_cnt}, 16'h0100);
    c_dir = 1; c_en = 1;
    #1;
    checkOutput("casc_dn_co", {15'h0, lo_casc}, 16'h0001);
    tick();
    c_en = 0;
    checkOutput("casc_dn_cnt", {hi_cnt, lo_cnt}, 16'h00FF);

    // 4-bit sweep against a behavioural model
    for (int c = 0; c < 16; c++) begin
      for (int m = 0; m < 4; m++) begin
        e_load = 1; e_val = 4'(c); e_en = 0;
        tick();
        e_load = 0; e_en = m[0]; e_dir = m[1];
        #1;
        if (m[1] == 0) begin
          co  = (m[0] == 1 && c == 15) ? 1 : 0;
          z   = (c + m[0]) & 15;
          bnd = (c == 15) ? 1 : 0;
        end else begin
          co  = (m[0] == 1 && c == 0) ? 1 : 0;
          z   = (c - m[0]) & 15;
          bnd = (c == 0) ? 1 : 0;
        end
        checkOutput($sformatf("ex_w_casc c%0d m%0d", c, m), {15'h0, ew_casc}, 16'(co));
        checkOutput($sformatf("ex_s_casc c%0d m%0d", c, m), {15'h0, es_casc}, 16'(co));
        checkOutput($sformatf("ex_w_bnd c%0d m%0d", c, m), {15'h0, ew_bnd}, 16'(bnd));
        checkOutput($sformatf("ex_s_bnd c%0d m%0d", c, m), {15'h0, es_bnd}, 16'(bnd));
        tick();
        checkOutput($sformatf("ex_w_cnt c%0d m%0d", c, m), {12'h0, ew_cnt}, 16'(z));
        checkOutput($sformatf("ex_w_wrap c%0d m%0d", c, m), {15'h0, ew_wrap}, 16'(co));
        checkOutput($sformatf("ex_s_cnt c%0d m%0d", c, m), {12'h0, es_cnt}, (co == 1) ? 16'(c) : 16'(z));
        checkOutput($sformatf("ex_s_wrap c%0d m%0d", c, m), {15'h0, es_wrap}, 16'(co));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
